// File: rtl/mips_core_pkg.sv
// ============================================================================
//  Module      : mips_core_pkg
//  Description : Shared MIPS core definitions: control-transfer opcodes,
//                fetch entry layout and the branch/jump pre-decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    typedef struct packed {
        logic [`ADDR_WIDTH-1:0] pc;
        logic [31:0]            inst;
    } fetch_entry_t;

    // True for any instruction that redirects the PC (branches, jumps, jr/jalr).
    function automatic logic is_ctrl_xfer(input logic [31:0] inst);
        logic r_hit;
        r_hit = 1'b0;
        case (inst[31:26])
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                r_hit = 1'b1;
            OP_SPECIAL:
                r_hit = (inst[5:0] == FUNCT_JR) || (inst[5:0] == FUNCT_JALR);
            default:
                r_hit = 1'b0;
        endcase
        return r_hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/thread_inst_fifo.sv
// ============================================================================
//  Module      : thread_inst_fifo
//  Description : Single-thread instruction FIFO with push/pop/flush and
//                full/empty status; head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module thread_inst_fifo
    import mips_core_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  ENTRY_T push_data,
    input  logic   pop,
    input  logic   flush,
    output ENTRY_T head,
    output logic   full,
    output logic   empty
);

    localparam int c_AW = $clog2(DEPTH);

    ENTRY_T           r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes a wrapped (full) FIFO from an empty one.
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign head   = r_mem[r_rd_ptr[c_AW-1:0]];

    assign w_push = push && !full  && !flush;
    assign w_pop  = pop  && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full && !flush)
    );

endmodule

`default_nettype wire

// File: rtl/mt_fetch_decode_queue.sv
// ============================================================================
//  Module      : mt_fetch_decode_queue
//  Description : Per-thread fetch buffers with round-robin arbitration into a
//                registered decode stage; blocks threads on control transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mt_fetch_decode_queue
    import mips_core_pkg::*;
#(
    parameter int NUM_THREADS     = 4,
    parameter int DEPTH           = 4,
    parameter int ADDR_WIDTH      = `ADDR_WIDTH,
    parameter bit BLOCK_ON_BRANCH = 1'b1,
    parameter int TID_W           = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [TID_W-1:0]       in_tid,
    input  logic [ADDR_WIDTH-1:0]  in_pc,
    input  logic [31:0]            in_inst,
    output logic [NUM_THREADS-1:0] in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TID_W-1:0]       out_tid,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [31:0]            out_inst,
    input  logic [NUM_THREADS-1:0] flush,
    input  logic                   resolve_valid,
    input  logic [TID_W-1:0]       resolve_tid,
    output logic [NUM_THREADS-1:0] blocked
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           inst;
    } entry_t;

    entry_t                 w_push_data;
    entry_t                 w_head [NUM_THREADS];
    entry_t                 w_grant_entry;
    logic [NUM_THREADS-1:0] w_full;
    logic [NUM_THREADS-1:0] w_empty;
    logic [NUM_THREADS-1:0] w_push;
    logic [NUM_THREADS-1:0] w_pop;
    logic [NUM_THREADS-1:0] w_eligible;
    logic [NUM_THREADS-1:0] w_blocked_nxt;
    logic                   w_load_en;
    logic                   w_grant_vld;
    logic [TID_W-1:0]       w_grant_tid;
    logic [TID_W-1:0]       w_rr_nxt;
    logic                   w_set_block;

    logic                   r_out_valid;
    logic [TID_W-1:0]       r_out_tid;
    logic [ADDR_WIDTH-1:0]  r_out_pc;
    logic [31:0]            r_out_inst;
    logic [NUM_THREADS-1:0] r_blocked;
    logic [TID_W-1:0]       r_rr_ptr;

    assign w_push_data = '{pc: in_pc, inst: in_inst};
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_eligible  = ~w_empty & ~r_blocked & ~flush;

    generate
        for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thread_fifo
            assign w_push[g] = in_valid && (in_tid == TID_W'(g));
            assign w_pop[g]  = w_load_en && w_grant_vld && (w_grant_tid == TID_W'(g));

            thread_inst_fifo #(
                .DEPTH   (DEPTH),
                .ENTRY_T (entry_t)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[g]),
                .push_data (w_push_data),
                .pop       (w_pop[g]),
                .flush     (flush[g]),
                .head      (w_head[g]),
                .full      (w_full[g]),
                .empty     (w_empty[g])
            );
        end
    endgenerate

    // Round-robin scan starting at r_rr_ptr, wrapping at NUM_THREADS.
    always_comb begin
        logic [TID_W:0] v_idx;
        v_idx       = '0;
        w_grant_vld = 1'b0;
        w_grant_tid = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            v_idx = {1'b0, r_rr_ptr} + (TID_W+1)'(i);
            if (v_idx >= (TID_W+1)'(NUM_THREADS)) begin
                v_idx = v_idx - (TID_W+1)'(NUM_THREADS);
            end
            if (!w_grant_vld && w_eligible[v_idx[TID_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_tid = v_idx[TID_W-1:0];
            end
        end
    end

    assign w_grant_entry = w_head[w_grant_tid];
    assign w_rr_nxt      = (w_grant_tid == TID_W'(NUM_THREADS - 1)) ? '0 : w_grant_tid + 1'b1;
    assign w_set_block   = BLOCK_ON_BRANCH && w_load_en && w_grant_vld &&
                           is_ctrl_xfer(w_grant_entry.inst);

    // Block set beats resolve; flush beats both.
    always_comb begin
        w_blocked_nxt = r_blocked;
        if (resolve_valid) w_blocked_nxt[resolve_tid] = 1'b0;
        if (w_set_block)   w_blocked_nxt[w_grant_tid] = 1'b1;
        w_blocked_nxt = w_blocked_nxt & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_tid   <= '0;
            r_out_pc    <= '0;
            r_out_inst  <= '0;
            r_blocked   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_blocked <= w_blocked_nxt;
            if (w_load_en) begin
                r_out_valid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_out_tid  <= w_grant_tid;
                    r_out_pc   <= w_grant_entry.pc;
                    r_out_inst <= w_grant_entry.inst;
                    r_rr_ptr   <= w_rr_nxt;
                end
            end else if (flush[r_out_tid]) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = ~w_full;
    assign out_valid = r_out_valid;
    assign out_tid   = r_out_tid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign blocked   = r_blocked;

endmodule

`default_nettype wire

// File: tb/tb_mt_fetch_decode_queue.sv
// ============================================================================
//  Module      : tb_mt_fetch_decode_queue
//  Description : Directed self-checking bench for mt_fetch_decode_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mt_fetch_decode_queue;

    localparam int NT = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic [1:0]    in_tid;
    logic [AW-1:0] in_pc;
    logic [31:0]   in_inst;
    logic [NT-1:0] in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_tid;
    logic [AW-1:0] out_pc;
    logic [31:0]   out_inst;
    logic [NT-1:0] flush;
    logic          resolve_valid;
    logic [1:0]    resolve_tid;
    logic [NT-1:0] blocked;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mt_fetch_decode_queue #(
        .NUM_THREADS     (NT),
        .DEPTH           (4),
        .ADDR_WIDTH      (AW),
        .BLOCK_ON_BRANCH (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_tid        (in_tid),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_tid       (out_tid),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .flush         (flush),
        .resolve_valid (resolve_valid),
        .resolve_tid   (resolve_tid),
        .blocked       (blocked)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tid, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_tid   = 2'(tid);
        in_pc    = pc;
        in_inst  = inst;
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        flush         = '0;
        resolve_valid = 1'b0;
    endtask

    function automatic logic [31:0] rr_pc(input int t, input int k);
        return 32'h1000 + 32'(t) * 32'h100 + 32'(k) * 32'h4;
    endfunction

    initial begin
        in_valid = 1'b0; in_tid = '0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; flush = '0; resolve_valid = 1'b0; resolve_tid = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_in_ready",  64'(in_ready),  'hF);
        check("rst_blocked",   64'(blocked),   0);
        check("rst_out_tid",   64'(out_tid),   0);
        check("rst_out_pc",    64'(out_pc),    0);
        check("rst_out_inst",  64'(out_inst),  0);
        rst_n = 1'b1;

        // Single push latency
        out_ready = 1'b1;
        push(0, 32'h100, 32'h20010005);
        tick(); idle();
        check("lat_not_yet", 64'(out_valid), 0);
        tick();
        check("lat_valid",   64'(out_valid), 1);
        check("lat_tid",     64'(out_tid),   0);
        check("lat_pc",      64'(out_pc),    'h100);
        check("lat_inst",    64'(out_inst),  'h20010005);
        check("lat_blocked", 64'(blocked),   0);
        tick();
        check("lat_drained", 64'(out_valid), 0);

        // Fill all threads with the output stalled, then drain round-robin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(0, rr_pc(0, k), 32'h20010000 + 32'(k));
            tick();
            if (k == 3) check("fill_t0_ready3", 64'(in_ready[0]), 1);
        end
        check("fill_t0_full", 64'(in_ready), 'hE);
        for (int t = 1; t < NT; t++) begin
            for (int k = 0; k < 4; k++) begin
                push(t, rr_pc(t, k), 32'h20010000 + 32'(t * 16 + k));
                tick();
            end
        end
        idle();
        check("fill_all_full", 64'(in_ready), 0);
        check("fill_hold_pc",  64'(out_pc),   64'(rr_pc(0, 0)));
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("rr_valid", 64'(out_valid), 1);
            check("rr_tid",   64'(out_tid),   64'((i + 1) % NT));
            check("rr_pc",    64'(out_pc),    64'(rr_pc((i + 1) % NT, (i + 1) / NT)));
        end
        tick();
        check("rr_drained",  64'(out_valid), 0);
        check("rr_ready_ok", 64'(in_ready),  'hF);

        // Branch blocking and resolve
        push(1, 32'h200, 32'h10220003);
        tick();
        push(1, 32'h204, 32'h20010204);
        tick();
        check("br_valid",   64'(out_valid), 1);
        check("br_pc",      64'(out_pc),    'h200);
        check("br_blocked", 64'(blocked),   'h2);
        push(2, 32'h300, 32'h20010300);
        tick(); idle();
        check("br_skip_bubble", 64'(out_valid), 0);
        tick();
        check("br_other_tid", 64'(out_tid), 2);
        check("br_other_pc",  64'(out_pc),  'h300);
        tick();
        check("br_still_blk", 64'(out_valid), 0);
        check("br_blk_held",  64'(blocked),   'h2);
        resolve_valid = 1'b1; resolve_tid = 2'd1;
        tick(); idle();
        check("res_cleared", 64'(blocked),   0);
        check("res_no_load", 64'(out_valid), 0);
        tick();
        check("res_t1_valid", 64'(out_valid), 1);
        check("res_t1_pc",    64'(out_pc),    'h204);

        // Block set and resolve on the same edge: set wins
        push(0, 32'h400, 32'h0C000040);
        tick(); idle();
        resolve_valid = 1'b1; resolve_tid = 2'd0;
        tick();
        check("setwin_blocked", 64'(blocked), 'h1);
        check("setwin_pc",      64'(out_pc),  'h400);
        tick(); idle();
        check("setwin_resolved", 64'(blocked), 0);

        // Stalled output holds, then flush of its thread
        out_ready = 1'b0;
        push(2, 32'h500, 32'h20010500);
        tick();
        push(2, 32'h504, 32'h20010504);
        tick(); idle();
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold_valid", 64'(out_valid), 1);
            check("hold_pc",    64'(out_pc),    'h500);
            check("hold_inst",  64'(out_inst),  'h20010500);
        end
        flush = 4'b0100;
        tick(); idle();
        check("fl2_out_clear", 64'(out_valid), 0);
        check("fl2_ready",     64'(in_ready),  'hF);
        out_ready = 1'b1;
        tick(); tick();
        check("fl2_fifo_empty", 64'(out_valid), 0);

        // Flush + push + resolve on the same thread in one cycle
        push(3, 32'h600, 32'h14000000);
        tick();
        push(3, 32'h604, 32'h20010604);
        tick(); idle();
        check("fl3_blocked_set", 64'(blocked), 'h8);
        tick();
        flush = 4'b1000;
        push(3, 32'h608, 32'h20010608);
        resolve_valid = 1'b1; resolve_tid = 2'd3;
        tick(); idle();
        check("fl3_blocked_clr", 64'(blocked),  0);
        check("fl3_ready",       64'(in_ready), 'hF);
        tick(); tick();
        check("fl3_fifo_empty", 64'(out_valid), 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(0, 32'h800 + 32'(k * 4), 32'h20010800);
            tick();
        end
        for (int t = 1; t < NT; t++) begin
            for (int k = 0; k < 3; k++) begin
                push(t, 32'h800 + 32'(t * 16 + k * 4), 32'h20010800);
                tick();
            end
        end
        idle();
        check("mid_busy", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   64'(out_valid), 0);
        check("mid_rst_ready",   64'(in_ready),  'hF);
        check("mid_rst_pc",      64'(out_pc),    0);
        check("mid_rst_blocked", 64'(blocked),   0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        check("mid_fifos_empty", 64'(out_valid), 0);
        push(2, 32'h900, 32'h20010900);
        tick(); idle();
        tick();
        check("mid_after_tid", 64'(out_tid), 2);
        check("mid_after_pc",  64'(out_pc),  'h900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mt_fetch_decode_queue.md
Name: mt_fetch_decode_queue

Overview:
- Per-thread instruction buffer plus arbiter between instruction fetch and the combinational decoder in the multithreaded MIPS core.
- Fetch pushes thread-tagged {pc, inst} words into NUM_THREADS independent FIFOs.
- A round-robin arbiter picks one eligible thread per cycle into a registered output stage that feeds decode.
- Pre-decodes branch/jump opcodes and can block a thread until its control transfer resolves. Supports per-thread flush.

Parameters:
- NUM_THREADS, 4, hardware thread count (≥2).
- DEPTH, 4, entries per thread FIFO (power of 2, ≥2).
- ADDR_WIDTH, `ADDR_WIDTH, pc width.
- BLOCK_ON_BRANCH, 1, 1 = thread ineligible after a branch/jump is issued until resolved; 0 = never block.
- TID_W, max(1,$clog2(NUM_THREADS)), thread id width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch word valid
- in_tid  in  TID_W  thread of fetch word
- in_pc  in  ADDR_WIDTH  pc of fetch word
- in_inst  in  32  instruction word
- in_ready  out  NUM_THREADS  bit t = FIFO t not full
- out_valid  out  1  output stage holds an instruction
- out_ready  in  1  decode accepts output
- out_tid  out  TID_W  thread of output
- out_pc  out  ADDR_WIDTH  pc of output
- out_inst  out  32  instruction of output
- flush  in  NUM_THREADS  bit t = discard all thread-t state
- resolve_valid  in  1  branch/jump resolved
- resolve_tid  in  TID_W  thread whose branch resolved
- blocked  out  NUM_THREADS  per-thread block flags

Behaviour:
- One clock (clk); asynchronous active-low reset (rst_n).
- Reset state: all FIFOs empty, out_valid=0, out_tid/out_pc/out_inst=0, blocked=0, round-robin pointer=0.
- in_ready is combinational from FIFO counts only, so it reads all-ones during and after reset.
- Push: when in_valid && in_ready[in_tid], write the entry at the rising edge.
  - A push to a full FIFO is illegal; it is dropped and asserts in simulation.
  - in_ready does not consider a same-cycle pop, so a full FIFO refuses the push even while popping.
- Output stage loads when !out_valid || out_ready (load_en). While out_valid && !out_ready, all out_* hold stable.
- Eligibility of thread t: FIFO t non-empty && !blocked[t] && !flush[t].
- Arbitration: on load_en, grant the first eligible thread scanning from rr_ptr upward with wrap, pop its head into the output stage, and set rr_ptr = granted+1 mod NUM_THREADS.
  - No eligible thread: out_valid=0 after the edge (if load_en), rr_ptr unchanged.
- Latency: a push at edge n becomes visible at out_* after edge n+1 at the earliest. There is no bypass.
- Pre-decode: an instruction is a branch/jump if opcode[31:26] ∈ {01,02,03,04,05,06,07}, or opcode=00 with funct[5:0] ∈ {08,09}.
  - With BLOCK_ON_BRANCH=1, loading such an instruction sets blocked[tid] at the same edge.
- Resolve: resolve_valid clears blocked[resolve_tid] next edge. Resolve for an unblocked thread is ignored.
  - Same-edge set (new branch load) and clear for the same thread: set wins.
- Flush[t]: FIFO t emptied, blocked[t] cleared, and a same-cycle push to t dropped.
  - If the output stage holds thread t, out_valid clears at that edge regardless of out_ready.
  - Flush has priority over resolve and over the block set.
  - Multiple flush bits may be active in one cycle.
- Pointer wrap: read/write pointers are log2(DEPTH)+1 bits; the MSB disambiguates full from empty.
- Reset mid-operation: asynchronously returns everything to the reset state; in-flight entries are lost.

Decomposition:
- Shared package (mips_core_pkg): add the opcode and funct constants used by pre-decode (OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, FUNCT_JR, FUNCT_JALR) and a fetch_entry_t struct {pc, inst}.
- Sub-module thread_inst_fifo, parametrised DEPTH and entry type, with push/pop/flush/full/empty. Instantiated NUM_THREADS times in a generate loop.
- Arbiter and output stage live in the top module.

Test Plan:
- Reset, then push t0 pc=0x100 inst=0x20010005 (addi), out_ready=1 → out_valid high two edges after push, out_tid=0, out_pc=0x100, blocked=0.
- Push 4 entries each to t0..t3 in back-to-back cycles, out_ready=1 → output tid sequence 0,1,2,3,0,1,… with no bubbles once all are non-empty; in_ready[t] drops after the 4th un-popped push.
- t1 issues beq 0x10220003 at pc=0x200 → blocked[1]=1, t1 skipped until resolve_valid with resolve_tid=1; the next t1 entry pc=0x204 appears only after the resolve.
- Output holds t2 instruction with out_ready=0 for 5 cycles → out_* stable; then flush[2]=1 → out_valid=0 next edge, FIFO 2 empty, in_ready[2]=1.
- Same cycle: flush[3]=1, push to t3, resolve_tid=3 → push dropped, blocked[3]=0, FIFO 3 empty.
- Assert rst_n low for 1 cycle mid-stream with all FIFOs at 3 entries → out_valid=0 and all FIFOs empty immediately; rr_ptr=0, so the first grant after release goes to the lowest eligible thread.
